dual_port_mem: RTL and testbench

DUAL_PORT_MEM -- requirements
Module: dual_port_mem

---
 rtl/dual_port_mem.sv | 155 +++++++++++++++
 tb/tb_dual_port_mem.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_mem.sv
// Dual-port word memory with a self-preloading controller.
// Ports: clk, rst (sync active-low); per-port we/address/dataIn,
//   registered dataOutA/dataOutB; displaySelect picks which one
//   drives displayData; ready flags end of preload sweep;
//   collision pulses when both ports write the same address.
module dual_port_mem #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 16,
    parameter int PRELOAD_N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              weA,
    input  logic              weB,
    input  logic [ADDR_W-1:0] addressA,
    input  logic [ADDR_W-1:0] addressB,
    input  logic [DATA_W-1:0] dataInA,
    input  logic [DATA_W-1:0] dataInB,
    input  logic              displaySelect,
    output logic [DATA_W-1:0] dataOutA,
    output logic [DATA_W-1:0] dataOutB,
    output logic [DATA_W-1:0] displayData,
    output logic              ready,
    output logic              collision
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_MAX = '1;
    localparam logic [ADDR_W:0] PRE_LIM = (ADDR_W + 1)'(PRELOAD_N);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] dout_a_q, dout_a_d;
    logic [DATA_W-1:0] dout_b_q, dout_b_d;
    logic              sel_q, sel_d;
    logic              coll_q, coll_d;

    logic              pre_we;
    logic              run_en;
    logic [DATA_W-1:0] pre_data;
    logic              we_a;
    logic              we_b;

    logic [DATA_W-1:0] mem [DEPTH];

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave INIT once the last address has been written
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_INIT: begin
                if (cnt_q == CNT_MAX) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // Controller outputs; rst gates memory writes on the reset edge
    always_comb begin
        ready  = (state_q == S_RUN);
        pre_we = rst && (state_q == S_INIT);
        run_en = rst && (state_q == S_RUN);
    end

    // Datapath next-state
    always_comb begin
        cnt_d    = cnt_q;
        pre_data = '0;
        dout_a_d = '0;
        dout_b_d = '0;
        sel_d    = 1'b0;

        if ({1'b0, cnt_q} < PRE_LIM) begin
            pre_data = DATA_W'(cnt_q) + DATA_W'(1);
        end

        // Counter saturates at the top address instead of wrapping
        if (pre_we && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + ADDR_W'(1);
        end

        coll_d = run_en && weA && weB && (addressA == addressB);
        we_a   = run_en && weA;
        we_b   = run_en && weB && !coll_d;

        // Reads use pre-edge contents, so a cross-port reader sees
        // old data; the writing port sees its own data. On a
        // collision port B reflects the word actually stored (A's).
        if (run_en) begin
            dout_a_d = weA ? dataInA : mem[addressA];
            if (weB) begin
                dout_b_d = coll_d ? dataInA : dataInB;
            end else begin
                dout_b_d = mem[addressB];
            end
            sel_d = displaySelect;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q    <= '0;
            dout_a_q <= '0;
            dout_b_q <= '0;
            sel_q    <= 1'b0;
            coll_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            dout_a_q <= dout_a_d;
            dout_b_q <= dout_b_d;
            sel_q    <= sel_d;
            coll_q   <= coll_d;
        end
    end

    // Storage has no reset; the preload sweep rewrites every word
    always_ff @(posedge clk) begin
        if (pre_we) begin
            mem[cnt_q] <= pre_data;
        end
        if (we_a) begin
            mem[addressA] <= dataInA;
        end
        if (we_b) begin
            mem[addressB] <= dataInB;
        end
    end

    assign dataOutA    = dout_a_q;
    assign dataOutB    = dout_b_q;
    assign displayData = sel_q ? dout_b_q : dout_a_q;
    assign collision   = coll_q;

endmodule

// File: tb/tb_dual_port_mem.sv
// Self-checking bench for dual_port_mem.
// Table-driven RUN vectors plus preload and reset sequences.
module tb_dual_port_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        weA, weB;
    logic [9:0]  addressA, addressB;
    logic [15:0] dataInA, dataInB;
    logic        displaySelect;
    logic [15:0] dataOutA, dataOutB, displayData;
    logic        ready, collision;

    int checks = 0;
    int failures = 0;

    dual_port_mem #(
        .ADDR_W(10),
        .DATA_W(16),
        .PRELOAD_N(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .weA(weA),
        .weB(weB),
        .addressA(addressA),
        .addressB(addressB),
        .dataInA(dataInA),
        .dataInB(dataInB),
        .displaySelect(displaySelect),
        .dataOutA(dataOutA),
        .dataOutB(dataOutB),
        .displayData(displayData),
        .ready(ready),
        .collision(collision)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wa;
        logic        wb;
        logic [9:0]  aa;
        logic [9:0]  ab;
        logic [15:0] da;
        logic [15:0] db;
        logic        sel;
        logic [15:0] ea;
        logic [15:0] eb;
        logic [15:0] ed;
        logic        ec;
        logic        cb;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(
        input logic wa, input logic wb,
        input logic [9:0] aa, input logic [9:0] ab,
        input logic [15:0] da, input logic [15:0] db,
        input logic sel,
        input logic [15:0] ea, input logic [15:0] eb,
        input logic [15:0] ed, input logic ec,
        input logic cb
    );
        vec_t v;
        v.wa = wa; v.wb = wb; v.aa = aa; v.ab = ab;
        v.da = da; v.db = db; v.sel = sel;
        v.ea = ea; v.eb = eb; v.ed = ed; v.ec = ec;
        v.cb = cb;
        return v;
    endfunction

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        weA = v.wa; weB = v.wb;
        addressA = v.aa; addressB = v.ab;
        dataInA = v.da; dataInB = v.db;
        displaySelect = v.sel;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        weA = 0; weB = 0; addressA = 0; addressB = 0;
        dataInA = 0; dataInB = 0; displaySelect = 0;
    endtask

    task automatic check_zero_outs(input string tag);
        check({tag, "_ready"}, 32'(ready), 32'd0);
        check({tag, "_doutA"}, 32'(dataOutA), 32'd0);
        check({tag, "_doutB"}, 32'(dataOutB), 32'd0);
        check({tag, "_disp"}, 32'(displayData), 32'd0);
        check({tag, "_coll"}, 32'(collision), 32'd0);
    endtask

    // Releases reset and counts edges until ready; inputs held
    task automatic wait_ready(input string tag);
        int n;
        bit got;
        got = 0;
        @(negedge clk);
        rst = 1;
        for (n = 1; n <= 1500; n++) begin
            @(posedge clk);
            #1;
            if (n == 600) begin
                check({tag, "_init_doutA"}, 32'(dataOutA), 32'd0);
                check({tag, "_init_disp"}, 32'(displayData), 32'd0);
            end
            if (ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            failures++;
            checks++;
            $display("FAIL %s_ready_timeout: no ready in 1500", tag);
        end else begin
            check({tag, "_ready_cycles"}, 32'(n), 32'd1024);
        end
    endtask

    task automatic read_check(input string tag,
                              input logic [9:0] a,
                              input logic [15:0] e);
        vec_t v;
        v = mk(0, 0, a, a, 0, 0, 1, 0, 0, 0, 0, 0);
        drive(v);
        check({tag, "_A"}, 32'(dataOutA), 32'(e));
        check({tag, "_B"}, 32'(dataOutB), 32'(e));
        check({tag, "_disp"}, 32'(displayData), 32'(e));
    endtask

    initial begin
        vecs[0]  = mk(0, 0, 0, 1, 0, 0, 0, 1, 2, 1, 0, 1);
        vecs[1]  = mk(0, 0, 2, 3, 0, 0, 1, 3, 4, 4, 0, 1);
        vecs[2]  = mk(0, 0, 5, 1023, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[3]  = mk(1, 0, 0, 1, 4, 0, 0, 4, 2, 4, 0, 1);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 4, 4, 4, 0, 1);
        vecs[5]  = mk(0, 1, 513, 513, 0, 5, 1, 0, 5, 5, 0, 1);
        vecs[6]  = mk(0, 0, 513, 2, 0, 0, 0, 5, 3, 5, 0, 1);
        vecs[7]  = mk(1, 1, 10, 10, 7, 9, 0, 7, 0, 7, 1, 0);
        vecs[8]  = mk(0, 0, 10, 10, 0, 0, 1, 7, 7, 7, 0, 1);
        vecs[9]  = mk(1, 1, 1, 1023, 16'hBEEF, 16'h1234, 1,
                      16'hBEEF, 16'h1234, 16'h1234, 0, 1);
        vecs[10] = mk(0, 0, 1023, 1, 0, 0, 0,
                      16'h1234, 16'hBEEF, 16'h1234, 0, 1);
        vecs[11] = mk(1, 0, 20, 20, 16'h55, 0, 1,
                      16'h55, 0, 0, 0, 1);
        vecs[12] = mk(0, 0, 20, 20, 0, 0, 0,
                      16'h55, 16'h55, 16'h55, 0, 1);

        // Reset held for several edges
        idle_inputs();
        rst = 0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outs("reset");

        // Writes attempted throughout INIT must be ignored
        weA = 1; addressA = 0; dataInA = 16'hFFFF;
        weB = 1; addressB = 1; dataInB = 16'hFFFF;
        wait_ready("pre1");

        read_check("rd0", 0, 1);
        read_check("rd1", 1, 2);
        read_check("rd2", 2, 3);
        read_check("rd3", 3, 4);
        read_check("rd5", 5, 0);

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i]);
            check($sformatf("v%0d_A", i),
                  32'(dataOutA), 32'(vecs[i].ea));
            if (vecs[i].cb) begin
                check($sformatf("v%0d_B", i),
                      32'(dataOutB), 32'(vecs[i].eb));
            end
            check($sformatf("v%0d_disp", i),
                  32'(displayData), 32'(vecs[i].ed));
            check($sformatf("v%0d_coll", i),
                  32'(collision), 32'(vecs[i].ec));
        end

        // Reset during RUN, with outputs nonzero beforehand
        @(negedge clk);
        idle_inputs();
        addressA = 1023; addressB = 1023; displaySelect = 1;
        rst = 0;
        @(posedge clk);
        #1;
        check_zero_outs("rst_run");

        // Restart preload, then reset again 500 cycles in
        @(negedge clk);
        rst = 1;
        repeat (500) @(posedge clk);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        check_zero_outs("rst_init");

        wait_ready("pre2");

        read_check("r2_0", 0, 1);
        read_check("r2_1", 1, 2);
        read_check("r2_2", 2, 3);
        read_check("r2_3", 3, 4);
        read_check("r2_5", 5, 0);
        read_check("r2_10", 10, 0);
        read_check("r2_513", 513, 0);
        read_check("r2_1023", 1023, 0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
